id_ex_stage_r0: RTL

Registered ID/EX pipeline boundary for the five-stage MIPS core. It latches decoded operands, register addresses and control bits from decode, and drives the EX-stage register addresses (`ex_rs`, `ex_rt`) consumed by the data forwarding unit. It detects load-use hazards against the instruction currently in EX, asserts `stall` to freeze PC and IF/ID, and injects a bubble. It also honours branch flush and memory-hold requests.

---
 rtl/id_ex_stage_r0.sv | 123 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage_r0.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_r0
// Purpose  : ID/EX pipeline register for the five-stage MIPS core. Latches the
//            decoded instruction, detects load-use hazards against the load
//            in EX, raises a combinational stall, and inserts bubbles on
//            hazard or branch flush. A memory hold freezes the whole register.
// Revision : r0 - initial release
// ============================================================================
module id_ex_stage_r0 #(
  parameter int BIT_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_useRs,
  input  logic                      id_useRt,
  input  logic [BIT_WIDTH-1:0]      id_rsData,
  input  logic [BIT_WIDTH-1:0]      id_rtData,
  input  logic [BIT_WIDTH-1:0]      id_imm,
  input  logic [3:0]                id_aluOp,
  input  logic                      id_aluSrc,
  input  logic                      id_regDst,
  input  logic                      id_memRead,
  input  logic                      id_memWrite,
  input  logic                      id_writeReg,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
  output logic [BIT_WIDTH-1:0]      ex_rsData,
  output logic [BIT_WIDTH-1:0]      ex_rtData,
  output logic [BIT_WIDTH-1:0]      ex_imm,
  output logic [3:0]                ex_aluOp,
  output logic                      ex_aluSrc,
  output logic                      ex_memRead,
  output logic                      ex_memWrite,
  output logic                      ex_writeReg,
  output logic [CNT_WIDTH-1:0]      ex_stallCount
);

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  logic                      hz;
  logic                      load_in_ex;
  logic                      rs_match;
  logic                      rt_match;
  logic [REG_ADDR_WIDTH-1:0] id_dest;

  // Hazard detection: a load writing a non-zero register sits in EX and the
  // decode-stage instruction reads that register.
  always_comb begin
    load_in_ex = ex_valid & ex_memRead & ex_writeReg & (ex_regToWrite != REG_ZERO);
    rs_match   = id_useRs & (id_rs == ex_regToWrite);
    rt_match   = id_useRt & (id_rt == ex_regToWrite);
    hz         = load_in_ex & id_valid & (rs_match | rt_match);
    stall      = (hz | hold) & ~flush;
    id_dest    = id_regDst ? id_rd : id_rt;
  end

  // EX register: flush > hold > hazard bubble > normal load. A bubble zeroes
  // every field so the forwarding unit can never match against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_regToWrite <= '0;
      ex_rsData     <= '0;
      ex_rtData     <= '0;
      ex_imm        <= '0;
      ex_aluOp      <= '0;
      ex_aluSrc     <= 1'b0;
      ex_memRead    <= 1'b0;
      ex_memWrite   <= 1'b0;
      ex_writeReg   <= 1'b0;
      ex_stallCount <= '0;
    end else if (flush || (!hold && hz)) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_regToWrite <= '0;
      ex_rsData     <= '0;
      ex_rtData     <= '0;
      ex_imm        <= '0;
      ex_aluOp      <= '0;
      ex_aluSrc     <= 1'b0;
      ex_memRead    <= 1'b0;
      ex_memWrite   <= 1'b0;
      ex_writeReg   <= 1'b0;
      // Only hazard bubbles are counted; a flush bubble leaves the count.
      if (!flush && (ex_stallCount != CNT_MAX)) begin
        ex_stallCount <= ex_stallCount + CNT_ONE;
      end
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_regToWrite <= id_dest;
      ex_rsData     <= id_rsData;
      ex_rtData     <= id_rtData;
      ex_imm        <= id_imm;
      ex_aluOp      <= id_aluOp;
      ex_aluSrc     <= id_aluSrc;
      // Side-effecting controls are suppressed for an empty decode slot.
      ex_memRead    <= id_memRead  & id_valid;
      ex_memWrite   <= id_memWrite & id_valid;
      ex_writeReg   <= id_writeReg & id_valid;
    end
  end

endmodule
`default_nettype wire
